hms_counter: RTL and testbench

Parametrised hours/minutes/seconds time-base counter with an internal tick prescaler. It supports up/down counting, parallel load, enable gating, and single-cycle carry pulses at each rollover. It runs from the system clock rather than a dedicated 1 Hz clock. It replaces the standalone seconds counter in the clock/timer datapath and feeds the display and alarm logic.

---
 rtl/time_pkg.sv | 15 +
 rtl/mod_counter.sv | 49 ++++
 rtl/hms_counter.sv | 98 +++++++++
 tb/tb_hms_counter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// Shared time-base constants and width helper for the hms counter.
// No ports: default moduli, default prescaler divide and clog2w().
package time_pkg;

    localparam int DEF_TICK_DIV = 50_000_000;
    localparam int DEF_SEC_MOD  = 60;
    localparam int DEF_MIN_MOD  = 60;
    localparam int DEF_HOUR_MOD = 24;

    // Bit width needed to hold 0..n-1; never less than one bit.
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Generic modulo-N up/down counter with clamped parallel load.
// Ports: clk, reset, step, down, load, load_val -> value, wrap (comb).
module mod_counter
    import time_pkg::*;
#(
    parameter int N = DEF_SEC_MOD,
    parameter int W = clog2w(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic         down,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] MAX = W'(N - 1);

    logic [W-1:0] load_clamped;
    logic         at_end;

    // Out-of-range loads saturate to the top count.
    always_comb begin
        load_clamped = load_val;
        if (32'(load_val) >= 32'(N)) begin
            load_clamped = MAX;
        end
    end

    assign at_end = down ? (value == '0) : (value == MAX);
    assign wrap   = step & at_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_clamped;
        end else if (step) begin
            if (down) begin
                value <= at_end ? MAX : value - 1'b1;
            end else begin
                value <= at_end ? '0 : value + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hms_counter.sv
// Hours/minutes/seconds time base with tick prescaler and carry pulses.
// Ports: clk, reset, en, down, load, load_* -> second, minute, hour, pulses.
module hms_counter
    import time_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int SEC_MOD  = DEF_SEC_MOD,
    parameter int MIN_MOD  = DEF_MIN_MOD,
    parameter int HOUR_MOD = DEF_HOUR_MOD,
    parameter int SW       = clog2w(SEC_MOD),
    parameter int MW       = clog2w(MIN_MOD),
    parameter int HW       = clog2w(HOUR_MOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          down,
    input  logic          load,
    input  logic [SW-1:0] load_sec,
    input  logic [MW-1:0] load_min,
    input  logic [HW-1:0] load_hour,
    output logic [SW-1:0] second,
    output logic [MW-1:0] minute,
    output logic [HW-1:0] hour,
    output logic          tick,
    output logic          one_min,
    output logic          one_hour,
    output logic          one_day
);

    localparam int PW = clog2w(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          step;
    logic          sec_wrap;
    logic          min_wrap;
    logic          hour_wrap;

    // Reset or load on the same edge swallows the step and its pulses.
    assign step = en & (presc == PMAX) & ~load & ~reset;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == PMAX) ? '0 : presc + 1'b1;
        end
    end

    mod_counter #(.N(SEC_MOD), .W(SW)) u_sec (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .down     (down),
        .load     (load),
        .load_val (load_sec),
        .value    (second),
        .wrap     (sec_wrap)
    );

    mod_counter #(.N(MIN_MOD), .W(MW)) u_min (
        .clk      (clk),
        .reset    (reset),
        .step     (sec_wrap),
        .down     (down),
        .load     (load),
        .load_val (load_min),
        .value    (minute),
        .wrap     (min_wrap)
    );

    mod_counter #(.N(HOUR_MOD), .W(HW)) u_hour (
        .clk      (clk),
        .reset    (reset),
        .step     (min_wrap),
        .down     (down),
        .load     (load),
        .load_val (load_hour),
        .value    (hour),
        .wrap     (hour_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tick     <= 1'b0;
            one_min  <= 1'b0;
            one_hour <= 1'b0;
            one_day  <= 1'b0;
        end else begin
            tick     <= step;
            one_min  <= sec_wrap;
            one_hour <= min_wrap;
            one_day  <= hour_wrap;
        end
    end

endmodule

// File: tb/tb_hms_counter.sv
// Directed self-checking bench for hms_counter with TICK_DIV=4.
// Drives and samples 1 time unit after each rising clock edge.
module tb_hms_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       down;
    logic       load;
    logic [5:0] load_sec;
    logic [5:0] load_min;
    logic [4:0] load_hour;
    logic [5:0] second;
    logic [5:0] minute;
    logic [4:0] hour;
    logic       tick;
    logic       one_min;
    logic       one_hour;
    logic       one_day;

    int checks = 0;
    int errors = 0;
    int ticks;

    always #5 clk = ~clk;

    hms_counter #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .down      (down),
        .load      (load),
        .load_sec  (load_sec),
        .load_min  (load_min),
        .load_hour (load_hour),
        .second    (second),
        .minute    (minute),
        .hour      (hour),
        .tick      (tick),
        .one_min   (one_min),
        .one_hour  (one_hour),
        .one_day   (one_day)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m,
                            input int s);
        chk({tag, ".hour"}, hour, h);
        chk({tag, ".min"}, minute, m);
        chk({tag, ".sec"}, second, s);
    endtask

    task automatic chk_pulses(input string tag, input int t, input int mi,
                              input int ho, input int d);
        chk({tag, ".tick"}, tick, t);
        chk({tag, ".one_min"}, one_min, mi);
        chk({tag, ".one_hour"}, one_hour, ho);
        chk({tag, ".one_day"}, one_day, d);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load      = 1'b1;
        load_hour = 5'(h);
        load_min  = 6'(m);
        load_sec  = 6'(s);
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; down = 1'b0; load = 1'b0;
        load_sec = '0; load_min = '0; load_hour = '0;
        cyc(2);
        chk_time("rst", 0, 0, 0);
        chk_pulses("rst", 0, 0, 0, 0);

        reset = 1'b0; en = 1'b1;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (tick) ticks++;
        end
        chk("run8.ticks", ticks, 2);
        chk_time("run8", 0, 0, 2);
        chk_pulses("run8", 1, 0, 0, 0);

        do_load(0, 0, 58);
        chk_time("ld58", 0, 0, 58);
        chk_pulses("ld58", 0, 0, 0, 0);
        cyc(4);
        chk_time("s59", 0, 0, 59);
        chk_pulses("s59", 1, 0, 0, 0);
        cyc(4);
        chk_time("m1", 0, 1, 0);
        chk_pulses("m1", 1, 1, 0, 0);
        cyc(1);
        chk_pulses("m1+1", 0, 0, 0, 0);

        do_load(23, 59, 59);
        cyc(4);
        chk_time("day", 0, 0, 0);
        chk_pulses("day", 1, 1, 1, 1);

        down = 1'b1;
        do_load(0, 0, 0);
        cyc(4);
        chk_time("dn1", 23, 59, 59);
        chk_pulses("dn1", 1, 1, 1, 1);
        cyc(4);
        chk_time("dn2", 23, 59, 58);
        chk_pulses("dn2", 1, 0, 0, 0);

        down = 1'b0;
        do_load(0, 0, 0);
        cyc(2);
        en = 1'b0;
        cyc(10);
        chk("hold.sec", second, 0);
        chk("hold.tick", tick, 0);
        en = 1'b1;
        cyc(1);
        chk("res1.sec", second, 0);
        chk("res1.tick", tick, 0);
        cyc(1);
        chk("res2.sec", second, 1);
        chk("res2.tick", tick, 1);

        cyc(3);
        do_load(1, 2, 3);
        chk_time("ldstep", 1, 2, 3);
        chk_pulses("ldstep", 0, 0, 0, 0);

        do_load(31, 63, 63);
        chk_time("clamp", 23, 59, 59);

        reset = 1'b1;
        do_load(5, 6, 7);
        reset = 1'b0;
        chk_time("rstld", 0, 0, 0);
        chk_pulses("rstld", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
